sid_audio_decim: RTL and testbench

Decimating sample collector that sits directly downstream of the SID filter/volume stage. It consumes the 18-bit signed mixed audio word once per SID cycle, box-car averages a power-of-two number of consecutive samples, and presents the result through a 2-entry valid/ready FIFO to the audio output path. An optional DC-blocking high-pass can be compiled in after the averager.

---
 rtl/sid_audio_decim.sv | 177 +++++++++++++++++
 tb/tb_sid_audio_decim.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_audio_decim.sv
// sid_audio_decim: box-car decimator for the SID mixed audio word.
// Averages 2^shift consecutive ce-qualified samples, optionally passes the
// result through a DC-blocking high-pass (compile with SID_DCBLOCK_EN), and
// hands results to a 2-entry first-word-fall-through FIFO.
//
// Output handshake: a result is transferred on every clock edge where
// out_valid and out_ready are both high. out_valid and out_sample come from
// registers only; out_ready affects only which entry is at the head after the
// edge.
module sid_audio_decim #(
  parameter int DC_SHIFT = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [17:0] audio_in,
  input  logic [3:0]  shift,
  output logic [17:0] out_sample,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow
);

  // The pole shift only makes sense in 4..15; catch bad overrides at elaboration.
  if (DC_SHIFT < 4 || DC_SHIFT > 15) begin : g_bad_dc_shift
    $error("sid_audio_decim: DC_SHIFT must be in 4..15");
  end

  localparam logic [0:0] ST_START = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  logic [0:0]         state;
  logic signed [25:0] acc;
  logic [7:0]         cnt;
  logic [3:0]         shift_l;

  logic [3:0]         eff_shift;
  logic [3:0]         win_shift;
  logic signed [25:0] samp_ext;
  logic signed [25:0] sum;
  logic [8:0]         cnt_next;
  logic               win_done;
  logic [17:0]        result;

  // Window arithmetic: the sample being accepted joins the running sum, and
  // the window closes when the count reaches 2^shift (9-bit compare so 256 fits).
  always_comb begin
    eff_shift = (shift > 4'd8) ? 4'd8 : shift;
    win_shift = (state == ST_START) ? eff_shift : shift_l;
    samp_ext  = {{8{audio_in[17]}}, audio_in};
    sum       = (state == ST_START) ? samp_ext : (acc + samp_ext);
    cnt_next  = (state == ST_START) ? 9'd1 : ({1'b0, cnt} + 9'd1);
    win_done  = ce && (cnt_next == (9'd1 << win_shift));
    result    = 18'(sum >>> win_shift);
  end

  // Window FSM and accumulator; shift is latched only at the start of a window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_START;
      acc     <= '0;
      cnt     <= '0;
      shift_l <= '0;
    end else if (ce) begin
      acc <= sum;
      cnt <= cnt_next[7:0];
      if (state == ST_START) shift_l <= eff_shift;
      state <= win_done ? ST_START : ST_ACCUM;
    end
  end

  logic [17:0] res_q;
  logic        res_v;

  // Result register: the averaged sample is presented one cycle after the
  // completing strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q <= '0;
      res_v <= 1'b0;
    end else begin
      res_v <= win_done;
      if (win_done) res_q <= result;
    end
  end

  logic [17:0] push_d;
  logic        push_v;

`ifdef SID_DCBLOCK_EN
  logic signed [17:0] x_prev;
  logic signed [17:0] y_prev;
  logic signed [17:0] y_leak;
  logic signed [19:0] y_full;
  logic [17:0]        y_sat;
  logic [17:0]        dc_q;
  logic               dc_v;

  // One-pole DC blocker in 20 bits, saturated back to the 18-bit range.
  always_comb begin
    y_leak = y_prev >>> DC_SHIFT;
    y_full = {{2{res_q[17]}}, res_q} - {{2{x_prev[17]}}, x_prev}
           + {{2{y_prev[17]}}, y_prev} - {{2{y_leak[17]}}, y_leak};
    if (y_full > 20'sd131071)       y_sat = 18'h1FFFF;
    else if (y_full < -20'sd131072) y_sat = 18'h20000;
    else                            y_sat = y_full[17:0];
  end

  // Blocker state and its output register (adds one cycle of latency).
  always_ff @(posedge clk) begin
    if (reset) begin
      x_prev <= '0;
      y_prev <= '0;
      dc_q   <= '0;
      dc_v   <= 1'b0;
    end else begin
      dc_v <= res_v;
      if (res_v) begin
        x_prev <= res_q;
        y_prev <= y_sat;
        dc_q   <= y_sat;
      end
    end
  end

  assign push_d = dc_q;
  assign push_v = dc_v;
`else
  assign push_d = res_q;
  assign push_v = res_v;
`endif

  logic [17:0] ent0;
  logic [17:0] ent1;
  logic [1:0]  fcnt;
  logic        ovf_q;
  logic        pop;

  assign pop        = (fcnt != 2'd0) && out_ready;
  assign out_sample = ent0;
  assign out_valid  = (fcnt != 2'd0);
  assign overflow   = ovf_q;

  // Two-entry FIFO with the head held in ent0; a push into a full FIFO is
  // dropped unless a pop frees a slot on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent0  <= '0;
      ent1  <= '0;
      fcnt  <= '0;
      ovf_q <= 1'b0;
    end else if (push_v && !pop) begin
      case (fcnt)
        2'd0: begin
          ent0 <= push_d;
          fcnt <= 2'd1;
        end
        2'd1: begin
          ent1 <= push_d;
          fcnt <= 2'd2;
        end
        default: ovf_q <= 1'b1;
      endcase
    end else if (!push_v && pop) begin
      ent0 <= ent1;
      fcnt <= fcnt - 2'd1;
    end else if (push_v && pop) begin
      if (fcnt == 2'd1) begin
        ent0 <= push_d;
      end else begin
        ent0 <= ent1;
        ent1 <= push_d;
      end
    end
  end

endmodule

// File: tb/tb_sid_audio_decim.sv
// Directed testbench for sid_audio_decim. Default build checks the plain
// averager; with SID_DCBLOCK_EN defined it checks the DC-blocker outputs.
module tb_sid_audio_decim;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [17:0] audio_in;
  logic [3:0]  shift;
  logic [17:0] out_sample;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  logic [17:0] got_q[$];
  logic [17:0] exp_q[$];

  sid_audio_decim #(.DC_SHIFT(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .audio_in   (audio_in),
    .shift      (shift),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow)
  );

  // Clock
  always #5 clk = ~clk;

  // Record every accepted output, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) got_q.push_back(out_sample);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [17:0] v);
    ce = 1'b1;
    audio_in = v;
    tick();
    ce = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    ce = 1'b0;
    idle(2);
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ce = 1'b0;
    audio_in = '0;
    shift = '0;
    out_ready = 1'b0;
    idle(3);
    n_vec++;
    if ({out_sample, out_valid, overflow} !== 20'd0) begin
      n_err++;
      $display("FAIL reset_state: sample=%h valid=%b ovf=%b, expected 0/0/0", out_sample, out_valid, overflow);
    end
    reset = 1'b0;
    got_q.delete();
  endtask

`ifndef SID_DCBLOCK_EN
  task automatic test_constant;
    do_reset();
    shift = 4'd2;
    out_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 4; k++) begin
        send(18'd1000);
        if (w == 0 && k == 3) begin
          n_vec++;
          if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_t1: valid=%b, expected 0", out_valid);
          end
          tick();
          n_vec++;
          if (out_valid !== 1'b1 || out_sample !== 18'd1000) begin
            n_err++;
            $display("FAIL latency_t2: valid=%b sample=%0d, expected 1/1000", out_valid, $signed(out_sample));
          end
          idle(6);
        end else begin
          idle(7);
        end
      end
    end
    idle(4);
    repeat (3) exp_q.push_back(18'd1000);
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL constant_count: got %0d outputs, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL constant[%0d]: got %0d, expected %0d", i, $signed(got_q[i]), $signed(exp_q[i]));
      end
    end
  endtask

  task automatic test_floor_extremes;
    do_reset();
    out_ready = 1'b1;
    shift = 4'd2;
    send(18'h3FFFF);
    repeat (3) send(18'd0);
    shift = 4'd8;
    repeat (256) send(18'h1FFFF);
    repeat (256) send(18'h20000);
    idle(5);
    exp_q = '{18'h3FFFF, 18'h1FFFF, 18'h20000};
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL floor_count: got %0d outputs, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL floor[%0d]: got %0d, expected %0d", i, $signed(got_q[i]), $signed(exp_q[i]));
      end
    end
  endtask

  task automatic test_overflow;
    do_reset();
    out_ready = 1'b0;
    shift = 4'd0;
    send(18'd1);
    send(18'd2);
    send(18'd3);
    n_vec++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_early: overflow=%b, expected 0", overflow);
    end
    idle(3);
    n_vec++;
    if (out_valid !== 1'b1 || out_sample !== 18'd1 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_full: valid=%b head=%0d ovf=%b, expected 1/1/1", out_valid, out_sample, overflow);
    end
    out_ready = 1'b1;
    idle(4);
    exp_q = '{18'd1, 18'd2};
    n_vec++;
    if (got_q.size() != exp_q.size() || overflow !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_drain: count=%0d ovf=%b valid=%b, expected 2/1/0", got_q.size(), overflow, out_valid);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL ovf_drain[%0d]: got %0d, expected %0d", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    out_ready = 1'b0;
    shift = 4'd0;
    send(18'd10);
    send(18'd20);
    idle(3);
    send(18'd30);
    out_ready = 1'b1;
    idle(2);
    send(18'd5);
    send(18'd6);
    send(18'd7);
    send(18'd8);
    idle(4);
    exp_q = '{18'd10, 18'd20, 18'd30, 18'd5, 18'd6, 18'd7, 18'd8};
    n_vec++;
    if (got_q.size() != exp_q.size() || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_count: count=%0d ovf=%b, expected %0d/0", got_q.size(), overflow, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL b2b[%0d]: got %0d, expected %0d", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_shift_change;
    do_reset();
    out_ready = 1'b1;
    shift = 4'd3;
    send(18'd1);
    send(18'd2);
    shift = 4'd1;
    for (int v = 3; v <= 8; v++) send(18'(v));
    send(18'd10);
    send(18'd20);
    send(18'd7);
    send(18'd8);
    idle(5);
    exp_q = '{18'd4, 18'd15, 18'd7};
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL shiftchg_count: got %0d outputs, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL shiftchg[%0d]: got %0d, expected %0d", i, got_q[i], exp_q[i]);
      end
    end
    do_reset();
    shift = 4'd12;
    repeat (128) send(18'd3);
    repeat (128) send(18'd4);
    idle(5);
    n_vec++;
    if (got_q.size() != 1 || got_q[0] !== 18'd3) begin
      n_err++;
      $display("FAIL shift12: count=%0d first=%0d, expected 1 output of 3", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 18'd0);
    end
  endtask

  task automatic test_reset_mid_window;
    do_reset();
    out_ready = 1'b1;
    shift = 4'd0;
    send(18'd777);
    idle(3);
    shift = 4'd4;
    repeat (7) send(18'd9999);
    reset = 1'b1;
    ce = 1'b1;
    audio_in = 18'd9999;
    tick();
    n_vec++;
    if ({out_sample, out_valid, overflow} !== 20'd0) begin
      n_err++;
      $display("FAIL reset_hold: sample=%0d valid=%b ovf=%b, expected 0/0/0", out_sample, out_valid, overflow);
    end
    tick();
    reset = 1'b0;
    ce = 1'b0;
    got_q.delete();
    repeat (15) send(18'd500);
    idle(4);
    n_vec++;
    if (got_q.size() != 0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_partial: count=%0d valid=%b, expected 0/0", got_q.size(), out_valid);
    end
    send(18'd500);
    idle(4);
    n_vec++;
    if (got_q.size() != 1 || got_q[0] !== 18'd500) begin
      n_err++;
      $display("FAIL reset_window: count=%0d first=%0d, expected 1 output of 500", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 18'd0);
    end
  endtask
`else
  task automatic test_dc_block;
    do_reset();
    out_ready = 1'b1;
    shift = 4'd0;
    repeat (3) send(18'd0);
    repeat (6) send(18'd10000);
    idle(6);
    exp_q = '{18'd0, 18'd0, 18'd0, 18'd10000, 18'd9981, 18'd9962, 18'd9943, 18'd9924, 18'd9905};
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL dc_step_count: got %0d outputs, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL dc_step[%0d]: got %0d, expected %0d", i, $signed(got_q[i]), $signed(exp_q[i]));
      end
    end
    do_reset();
    repeat (2) send(18'h20000);
    send(18'h1FFFF);
    idle(6);
    exp_q = '{18'h20000, 18'(-130816), 18'h1FFFF};
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL dc_full_count: got %0d outputs, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL dc_full[%0d]: got %0d, expected %0d", i, $signed(got_q[i]), $signed(exp_q[i]));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef SID_DCBLOCK_EN
    test_constant();
    test_floor_extremes();
    test_overflow();
    test_back_to_back();
    test_shift_change();
    test_reset_mid_window();
`else
    test_dc_block();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
